// File: rtl/mem_wb_stage_pkg.sv
// Shared types for the memory-access / write-back stage.
// Load-type codes match the execute stage's is_load_mem encoding.
package mem_wb_stage_pkg;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_W    = 3'd1,
    LD_H    = 3'd2,
    LD_B    = 3'd3,
    LD_HU   = 3'd4,
    LD_BU   = 3'd5,
    LD_FW   = 3'd6
  } load_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Shifts the raw memory word down to the addressed byte/half and extends it.
// Codes outside the defined load types fall back to full-word behaviour.
module load_align
  import mem_wb_stage_pkg::*;
(
  input  logic [31:0] dm_rdata,
  input  logic [1:0]  offset,
  input  load_t       ld_type,
  output logic [31:0] ld_data
);

  logic [31:0] sh;

  always_comb begin
    sh = dm_rdata >> {offset, 3'b000};
    case (ld_type)
      LD_B:    ld_data = {{24{sh[7]}}, sh[7:0]};
      LD_BU:   ld_data = {24'b0, sh[7:0]};
      LD_H:    ld_data = {{16{sh[15]}}, sh[15:0]};
      LD_HU:   ld_data = {16'b0, sh[15:0]};
      default: ld_data = dm_rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB register: issues loads, stalls on slow memory,
// aborts loads that exceed TIMEOUT_CYC wait cycles and flags them in dm_err.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_DEF,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_out_mem,
  input  logic [4:0]  rd_addr_mem,
  input  logic        wb_en_mem,
  input  logic        float_wb_en_mem,
  input  logic [2:0]  is_load_mem,
  output logic        dm_req,
  output logic [31:0] dm_addr,
  input  logic        dm_ready,
  input  logic [31:0] dm_rdata,
  output logic        mem_stall,
  output logic        dm_err,
  output logic [31:0] wb_data,
  output logic [4:0]  rd_addr_wb,
  output logic        wb_en_wb,
  output logic        float_wb_en_wb
);

  mem_state_t       state;
  logic [CNT_W-1:0] count;
  logic             is_load;
  logic             timeout;
  logic [31:0]      ld_data;
  logic [31:0]      wb_next;

  load_align u_align (
    .dm_rdata (dm_rdata),
    .offset   (alu_out_mem[1:0]),
    .ld_type  (load_t'(is_load_mem)),
    .ld_data  (ld_data)
  );

  assign is_load = (is_load_mem != LD_NONE);
  assign timeout = (state == WAIT) && !dm_ready && (count == CNT_W'(TIMEOUT_CYC));
  assign wb_next = is_load ? ld_data : alu_out_mem;
  assign dm_addr = {alu_out_mem[31:2], 2'b00};

  // Gated by rst so the request drops the instant reset asserts, even if
  // upstream still presents a load.
  always_comb begin
    dm_req    = rst && ((state == WAIT) || is_load);
    mem_stall = dm_req && !dm_ready && !timeout;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      count          <= '0;
      wb_data        <= '0;
      rd_addr_wb     <= '0;
      wb_en_wb       <= 1'b0;
      float_wb_en_wb <= 1'b0;
      dm_err         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!is_load || dm_ready) begin
            wb_data        <= wb_next;
            rd_addr_wb     <= rd_addr_mem;
            wb_en_wb       <= wb_en_mem;
            float_wb_en_wb <= float_wb_en_mem;
          end else begin
            state          <= WAIT;
            count          <= CNT_W'(1);
            wb_en_wb       <= 1'b0;
            float_wb_en_wb <= 1'b0;
          end
        end
        WAIT: begin
          if (dm_ready) begin
            state          <= IDLE;
            wb_data        <= wb_next;
            rd_addr_wb     <= rd_addr_mem;
            wb_en_wb       <= wb_en_mem;
            float_wb_en_wb <= float_wb_en_mem;
          end else if (timeout) begin
            // Abandoned load: write-back suppressed, error latched until reset.
            state          <= IDLE;
            dm_err         <= 1'b1;
            wb_en_wb       <= 1'b0;
            float_wb_en_wb <= 1'b0;
          end else begin
            count          <= count + CNT_W'(1);
            wb_en_wb       <= 1'b0;
            float_wb_en_wb <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed and randomized checks of mem_wb_stage against a transaction-level
// model: each load is described by its memory latency rather than by FSM state.
module tb_mem_wb_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_out_mem;
  logic [4:0]  rd_addr_mem;
  logic        wb_en_mem;
  logic        float_wb_en_mem;
  logic [2:0]  is_load_mem;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic        dm_ready;
  logic [31:0] dm_rdata;
  logic        mem_stall;
  logic        dm_err;
  logic [31:0] wb_data;
  logic [4:0]  rd_addr_wb;
  logic        wb_en_wb;
  logic        float_wb_en_wb;

  int checks = 0;
  int passed = 0;

  logic [31:0] exp_wb;
  logic [4:0]  exp_rd;
  logic        exp_en;
  logic        exp_fen;
  logic        exp_err;

  mem_wb_stage #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .alu_out_mem     (alu_out_mem),
    .rd_addr_mem     (rd_addr_mem),
    .wb_en_mem       (wb_en_mem),
    .float_wb_en_mem (float_wb_en_mem),
    .is_load_mem     (is_load_mem),
    .dm_req          (dm_req),
    .dm_addr         (dm_addr),
    .dm_ready        (dm_ready),
    .dm_rdata        (dm_rdata),
    .mem_stall       (mem_stall),
    .dm_err          (dm_err),
    .wb_data         (wb_data),
    .rd_addr_wb      (rd_addr_wb),
    .wb_en_wb        (wb_en_wb),
    .float_wb_en_wb  (float_wb_en_wb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Expected load result from the byte/half selection rules, in plain arithmetic.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input int off, input int t);
    longint sh;
    longint v;
    sh = longint'(w) / (longint'(1) << (8 * off));
    if (t == 3 || t == 5) begin
      v = sh % 256;
      if (t == 3 && v >= 128) v = v - 256;
    end else if (t == 2 || t == 4) begin
      v = sh % 65536;
      if (t == 2 && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(w);
    end
    return v[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".wb_data"}, wb_data, exp_wb);
    chk({tag, ".rd"}, 32'(rd_addr_wb), 32'(exp_rd));
    chk({tag, ".wb_en"}, 32'(wb_en_wb), 32'(exp_en));
    chk({tag, ".fwb_en"}, 32'(float_wb_en_wb), 32'(exp_fen));
    chk({tag, ".err"}, 32'(dm_err), 32'(exp_err));
  endtask

  // lat = number of request cycles before dm_ready (0 = zero-wait).
  task automatic txn(input string tag, input logic [31:0] addr, input logic [4:0] rd,
                     input logic wb, input logic fwb, input logic [2:0] ld,
                     input logic [31:0] rdata, input int lat);
    int     end_cyc;
    bit     ok;
    alu_out_mem     = addr;
    rd_addr_mem     = rd;
    wb_en_mem       = wb;
    float_wb_en_mem = fwb;
    is_load_mem     = ld;
    ok      = (ld == 3'd0) || (lat <= TO);
    end_cyc = (ld == 3'd0) ? 0 : ((lat <= TO) ? lat : TO);
    for (int c = 0; c <= end_cyc; c++) begin
      dm_ready = (ld != 3'd0) && (c == lat);
      dm_rdata = dm_ready ? rdata : $urandom;
      #1;
      chk({tag, ".req"}, 32'(dm_req), 32'(ld != 3'd0));
      if (ld != 3'd0) chk({tag, ".addr"}, dm_addr, addr & 32'hFFFF_FFFC);
      chk({tag, ".stall"}, 32'(mem_stall), 32'(c < end_cyc));
      tick();
      if (c < end_cyc) begin
        exp_en  = 1'b0;
        exp_fen = 1'b0;
        chk({tag, ".bubble_en"}, 32'(wb_en_wb), 32'(exp_en));
        chk({tag, ".bubble_data"}, wb_data, exp_wb);
      end
    end
    dm_ready = 1'b0;
    if (ok) begin
      exp_wb  = (ld == 3'd0) ? addr : ref_load(rdata, int'(addr[1:0]), int'(ld));
      exp_rd  = rd;
      exp_en  = wb;
      exp_fen = fwb;
    end else begin
      exp_en  = 1'b0;
      exp_fen = 1'b0;
      exp_err = 1'b1;
    end
    chk_regs(tag);
  endtask

  initial begin
    rst             = 1'b0;
    alu_out_mem     = '0;
    rd_addr_mem     = '0;
    wb_en_mem       = 1'b0;
    float_wb_en_mem = 1'b0;
    is_load_mem     = 3'd0;
    dm_ready        = 1'b0;
    dm_rdata        = '0;
    exp_wb = '0; exp_rd = '0; exp_en = 1'b0; exp_fen = 1'b0; exp_err = 1'b0;

    #1;
    is_load_mem = 3'd1;
    #1;
    chk("rst.req", 32'(dm_req), 32'd0);
    chk("rst.stall", 32'(mem_stall), 32'd0);
    chk_regs("rst");
    is_load_mem = 3'd0;
    tick();
    tick();
    rst = 1'b1;

    txn("nonload", 32'h1234_5678, 5'd5, 1'b1, 1'b0, 3'd0, 32'h0, 0);
    txn("lb_zw", 32'h0000_0103, 5'd7, 1'b1, 1'b0, 3'd3, 32'h80FF_0000, 0);
    txn("lhu_w2", 32'h0000_0202, 5'd8, 1'b1, 1'b0, 3'd4, 32'hBEEF_0000, 2);
    txn("flw", 32'h0000_0040, 5'd3, 1'b0, 1'b1, 3'd6, 32'h3F80_0000, 1);
    txn("lh_off3", 32'h0000_0013, 5'd9, 1'b1, 1'b0, 3'd2, 32'hF234_5678, 0);
    txn("ld7", 32'h0000_0022, 5'd10, 1'b1, 1'b0, 3'd7, 32'hA5A5_1234, 1);
    txn("lw_edge", 32'h0000_0080, 5'd11, 1'b1, 1'b0, 3'd1, 32'hDEAD_BEEF, TO);
    txn("timeout", 32'h0000_0300, 5'd12, 1'b1, 1'b0, 3'd1, 32'h1111_1111, 20);
    txn("after_to", 32'h0000_ABCD, 5'd13, 1'b1, 1'b0, 3'd0, 32'h0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] ld;
      ld = 3'($urandom_range(0, 7));
      txn("rand", $urandom, 5'($urandom), 1'($urandom), 1'($urandom), ld, $urandom,
          int'($urandom_range(0, TO + 2)));
    end

    // Reset while waiting on a slow load.
    alu_out_mem = 32'h0000_0400; rd_addr_mem = 5'd14; wb_en_mem = 1'b1;
    float_wb_en_mem = 1'b0; is_load_mem = 3'd1; dm_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    exp_wb = '0; exp_rd = '0; exp_en = 1'b0; exp_fen = 1'b0; exp_err = 1'b0;
    chk("midrst.req", 32'(dm_req), 32'd0);
    chk("midrst.stall", 32'(mem_stall), 32'd0);
    chk_regs("midrst");
    is_load_mem = 3'd0; alu_out_mem = 32'h0000_CAFE; rd_addr_mem = 5'd9;
    tick();
    rst = 1'b1;
    dm_ready = 1'b1;
    dm_rdata = 32'h5555_5555;
    #1;
    chk("postrst.req", 32'(dm_req), 32'd0);
    chk("postrst.stall", 32'(mem_stall), 32'd0);
    tick();
    dm_ready = 1'b0;
    exp_wb = 32'h0000_CAFE; exp_rd = 5'd9; exp_en = 1'b1; exp_fen = 1'b0;
    chk_regs("postrst");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register, directly downstream of the execute stage's EX/MEM register outputs.
- Issues load requests to a variable-latency data memory and stalls the pipeline until data returns.
- Aligns and sign- or zero-extends load data, then registers the result, destination and write-enables for write-back.
- Its registered write-back data is the WB forwarding source for the execute stage.

Parameters:
- TIMEOUT_CYC, 255, maximum WAIT cycles before a load is aborted (1..255).
- CNT_W, 8, width of the wait counter.

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- alu_out_mem  in  32  ALU result: load address, or write-back value for non-loads
- rd_addr_mem  in  5  destination register
- wb_en_mem  in  1  integer write-back enable
- float_wb_en_mem  in  1  FP write-back enable
- is_load_mem  in  3  load type, encoding from package; 0 means not a load
- dm_req  out  1  load request to data memory
- dm_addr  out  32  word address: {alu_out_mem[31:2], 2'b00}
- dm_ready  in  1  memory returns data this cycle
- dm_rdata  in  32  raw memory word
- mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM registers
- dm_err  out  1  sticky load-timeout flag
- wb_data  out  32  registered write-back data; also the WB forward value
- rd_addr_wb  out  5  registered destination
- wb_en_wb  out  1  registered integer write-back enable
- float_wb_en_wb  out  1  registered FP write-back enable

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0.
  - wb_data=0, rd_addr_wb=0, wb_en_wb=0, float_wb_en_wb=0, dm_err=0.
  - Combinational outputs settle to dm_req=0, mem_stall=0.
  - Reset mid-WAIT abandons the load; a dm_ready seen afterwards in IDLE is ignored.
- States: IDLE, WAIT.
- IDLE, is_load_mem==0:
  - dm_req=0, mem_stall=0.
  - Next edge: wb_data<=alu_out_mem; rd/wb_en/float_wb_en copied from the *_mem inputs.
- IDLE, is_load_mem!=0:
  - dm_req=1.
  - If dm_ready=1 in the same cycle (zero-wait): mem_stall=0; next edge registers the aligned load data and the control fields; stay in IDLE.
  - Otherwise: mem_stall=1; next edge goes to WAIT, counter<=1, and a bubble is registered (wb_en_wb=0, float_wb_en_wb=0; wb_data and rd_addr_wb hold).
- WAIT:
  - dm_req=1, dm_addr stable; upstream holds its *_mem inputs constant because mem_stall is 1.
  - dm_ready=1: mem_stall=0 that cycle; next edge registers the aligned data and control fields; go to IDLE.
  - dm_ready=0 and counter==TIMEOUT_CYC: mem_stall=0; next edge sets dm_err<=1, registers a bubble, goes to IDLE. The load is dropped and its write-back suppressed.
  - Otherwise: mem_stall=1, counter increments, bubble registered.
- Latency: write-back fields are valid one edge after the cycle in which dm_ready (or a non-load) is accepted.
- Load alignment: sh = dm_rdata >> (8*alu_out_mem[1:0]), zeros shifted in.
  - LB: sign-extend sh[7:0]. LBU: zero-extend sh[7:0].
  - LH: sign-extend sh[15:0]. LHU: zero-extend sh[15:0].
  - LW and FLW: dm_rdata unshifted.
  - Misaligned LH/LW is not trapped. LH at offset 3 yields {sign of 0, byte3} per the shift rule.
- Undefined is_load_mem codes (111) behave as LW.
- dm_err is cleared only by reset.
- Simultaneous reset and dm_ready: reset wins.

Decomposition:
- Shared package: load-type enum
  - LD_NONE=0, LD_W=1, LD_H=2, LD_B=3, LD_HU=4, LD_BU=5, LD_FW=6
  - mem_state_t {IDLE, WAIT}
  - default TIMEOUT_CYC
- Sub-module: load_align. Combinational; inputs dm_rdata, offset[1:0], load type; output 32-bit extended data.
- The FSM, counter and MEM/WB registers stay in mem_wb_stage.

Test Plan:
- Non-load: alu_out_mem=0x1234_5678, rd=5, wb_en=1 -> next edge wb_data=0x1234_5678, rd_addr_wb=5, wb_en_wb=1; dm_req=0, mem_stall=0 throughout.
- Zero-wait LB: addr=0x103, dm_rdata=0x80FF_0000, dm_ready=1 same cycle -> mem_stall=0, dm_addr=0x100; next edge wb_data=0xFFFF_FF80.
- LHU with 3-cycle wait: addr=0x202, dm_ready on the 3rd request cycle, dm_rdata=0xBEEF_0000 -> mem_stall=1 for 2 cycles, wb_en_wb=0 during them, then wb_data=0x0000_BEEF, wb_en_wb=1.
- FLW: float_wb_en=1, wb_en=0, dm_rdata=0x3F80_0000 -> float_wb_en_wb=1, wb_en_wb=0, wb_data=0x3F80_0000.
- Timeout: TIMEOUT_CYC=4, dm_ready held 0 -> mem_stall drops after the 4th WAIT cycle; dm_err=1 and stays 1; no write-back; the next non-load completes normally.
- Reset in WAIT: rst=0 mid-wait -> immediately dm_req=0, mem_stall=0, all registered outputs 0; a dm_ready pulse after release is ignored.
